switch_debounce_ctrl: RTL and testbench

Per-channel debounce controller that sits directly after the 2-flop switch synchronizer. It takes the synchronized switch bus SYNC and produces debounced levels DB with one-cycle RISE/FALL pulses. A round-robin scheduler serializes change events onto a single valid/ready event port, which feeds the display-mode configuration logic.

---
 rtl/switch_debounce_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_switch_debounce_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_ctrl.sv
// ============================================================================
// switch_debounce_ctrl
//
// Per-channel debounce controller placed after the 2-flop switch synchronizer.
// Each channel runs a two-state (STABLE/PEND) debounce FSM with its own
// counter. A debounced level DB[i] toggles only after DB_CYCLES+1 consecutive
// samples of the new SYNC value. RISE/FALL pulse for one cycle alongside the
// toggle. Qualifying toggles set a pending bit. A round-robin scheduler
// serializes pending channels onto one valid/ready event port.
//
// Build option:
//   DEBOUNCE_FALL_EVT_EN  defined   -> rising and falling toggles raise events
//                         undefined -> only rising toggles raise events
//
// Ports:
//   CLK        in   system clock, rising edge
//   ACLR_L     in   asynchronous active-low reset
//   SYNC       in   [N]     synchronized switch levels
//   DB         out  [N]     debounced levels
//   RISE       out  [N]     one-cycle pulse on DB 0->1
//   FALL       out  [N]     one-cycle pulse on DB 1->0
//   EVT_VALID  out          event presented
//   EVT_READY  in           consumer accepts event
//   EVT_IDX    out  [IDX_W] channel of presented event
//   EVT_LEVEL  out          DB level of that channel at presentation
//   OVERRUN    out          sticky: an event was merged/lost
//   OVR_CLR    in           synchronous clear of OVERRUN
// ============================================================================
module switch_debounce_ctrl #(
    parameter int N         = 8,
    parameter int IDX_W     = 3,
    parameter int CNT_W     = 20,
    parameter int DB_CYCLES = 500000
) (
    input  logic             CLK,
    input  logic             ACLR_L,
    input  logic [N-1:0]     SYNC,
    output logic [N-1:0]     DB,
    output logic [N-1:0]     RISE,
    output logic [N-1:0]     FALL,
    output logic             EVT_VALID,
    input  logic             EVT_READY,
    output logic [IDX_W-1:0] EVT_IDX,
    output logic             EVT_LEVEL,
    output logic             OVERRUN,
    input  logic             OVR_CLR
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Per-channel FSM state
    state_t           r_state     [N];
    state_t           w_state_nxt [N];
    logic [CNT_W-1:0] r_cnt       [N];
    logic [CNT_W-1:0] w_cnt_nxt   [N];

    logic [N-1:0]     r_db, r_rise, r_fall, r_pend;
    logic [N-1:0]     w_toggle, w_db_nxt, w_rise, w_fall;
    logic [N-1:0]     w_set, w_clr, w_cand, w_pend_nxt;
    logic             w_ovr;

    // Scheduler
    logic             r_evt_valid, r_evt_level, r_ovr;
    logic [IDX_W-1:0] r_evt_idx, r_ptr;
    logic             w_accept, w_load, w_found;
    logic [IDX_W-1:0] w_sel, w_ptr_nxt;

    // ------------------------------------------------------------------------
    // Debounce next-state logic
    // ------------------------------------------------------------------------
    always_comb begin : debounce_comb
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned; that is what keeps it free of latches.
        w_toggle = '0;
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    if (SYNC[i] != r_db[i]) begin
                        w_state_nxt[i] = ST_PEND;
                        w_cnt_nxt[i]   = '0;
                    end
                end
                ST_PEND: begin
                    if (SYNC[i] == r_db[i]) begin
                        // glitch rejected
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_toggle[i]    = 1'b1;
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_STABLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    assign w_db_nxt = r_db ^ w_toggle;
    assign w_rise   = w_toggle & w_db_nxt;
    assign w_fall   = w_toggle & ~w_db_nxt;

`ifdef DEBOUNCE_FALL_EVT_EN
    assign w_set = w_toggle;
`else
    assign w_set = w_rise;
`endif

    // ------------------------------------------------------------------------
    // Pending bits, overrun and round-robin selection
    // ------------------------------------------------------------------------
    assign w_accept = r_evt_valid & EVT_READY;
    assign w_load   = ~r_evt_valid | w_accept;

    always_comb begin : sched_comb
        int start;
        int c;
        w_clr = '0;
        for (int i = 0; i < N; i++) begin
            w_clr[i] = w_accept && (r_evt_idx == IDX_W'(i));
        end

        // A new set wins over a same-cycle clear; only a set landing on a
        // still-pending, not-accepted bit is an overrun.
        w_pend_nxt = (r_pend & ~w_clr) | w_set;
        w_ovr      = |(w_set & r_pend & ~w_clr);

        // The just-accepted channel is excluded even if it re-triggered
        // this cycle, so it waits its round-robin turn.
        w_cand = r_pend & ~w_clr;
        start  = w_accept ? (int'(r_evt_idx) + 1) % N : int'(r_ptr);
        w_ptr_nxt = w_accept ? IDX_W'((int'(r_evt_idx) + 1) % N) : r_ptr;

        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (!w_found && w_cand[c]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(c);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            // NOTE: the per-channel state/counter arrays are reset explicitly;
            // a channel left mid-count would otherwise debounce early.
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values regardless of statement order.
            for (int i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Debounced outputs, pending bits and event port
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ACLR_L) begin
        if (!ACLR_L) begin
            r_db        <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
            r_pend      <= '0;
            r_ovr       <= 1'b0;
            r_ptr       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_evt_level <= 1'b0;
        end else begin
            r_db   <= w_db_nxt;
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_pend <= w_pend_nxt;
            r_ovr  <= (r_ovr & ~OVR_CLR) | w_ovr;
            r_ptr  <= w_ptr_nxt;
            if (w_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_idx   <= w_sel;
                    // post-update level if this channel toggles on this edge
                    r_evt_level <= w_db_nxt[w_sel];
                end
            end
        end
    end

    assign DB        = r_db;
    assign RISE      = r_rise;
    assign FALL      = r_fall;
    assign EVT_VALID = r_evt_valid;
    assign EVT_IDX   = r_evt_idx;
    assign EVT_LEVEL = r_evt_level;
    assign OVERRUN   = r_ovr;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// ============================================================================
// tb_switch_debounce_ctrl
//
// Directed bench for switch_debounce_ctrl with N=8, DB_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// Expected values are hand-derived constants.
// ============================================================================
module tb_switch_debounce_ctrl;

    localparam int N         = 8;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 20;
    localparam int DB_CYCLES = 4;

    logic             CLK = 1'b0;
    logic             ACLR_L;
    logic [N-1:0]     SYNC;
    logic [N-1:0]     DB, RISE, FALL;
    logic             EVT_VALID, EVT_READY, EVT_LEVEL;
    logic [IDX_W-1:0] EVT_IDX;
    logic             OVERRUN, OVR_CLR;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] rise_acc;

    switch_debounce_ctrl #(
        .N(N), .IDX_W(IDX_W), .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)
    ) dut (
        .CLK(CLK), .ACLR_L(ACLR_L), .SYNC(SYNC),
        .DB(DB), .RISE(RISE), .FALL(FALL),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
        .EVT_IDX(EVT_IDX), .EVT_LEVEL(EVT_LEVEL),
        .OVERRUN(OVERRUN), .OVR_CLR(OVR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        ACLR_L    = 1'b0;
        SYNC      = '0;
        EVT_READY = 1'b0;
        OVR_CLR   = 1'b0;
        #3;
        check("rst_db", DB, 0);
        check("rst_rise", RISE, 0);
        check("rst_fall", FALL, 0);
        check("rst_valid", EVT_VALID, 0);
        check("rst_idx", EVT_IDX, 0);
        check("rst_level", EVT_LEVEL, 0);
        check("rst_ovr", OVERRUN, 0);
        tick();
        tick();
        ACLR_L = 1'b1;

        // ---- channel 0 rises: DB on 5th edge, event one cycle later ----
        SYNC[0] = 1'b1;
        repeat (4) tick();
        check("ch0_db_edge4", DB, 8'h00);
        tick();
        check("ch0_db_edge5", DB, 8'h01);
        check("ch0_rise", RISE, 8'h01);
        check("ch0_valid_early", EVT_VALID, 0);
        tick();
        check("ch0_rise_off", RISE, 8'h00);
        check("ch0_valid", EVT_VALID, 1);
        check("ch0_idx", EVT_IDX, 0);
        check("ch0_level", EVT_LEVEL, 1);
        tick();
        check("ch0_hold_valid", EVT_VALID, 1);
        check("ch0_hold_idx", EVT_IDX, 0);
        EVT_READY = 1'b1;
        tick();
        check("ch0_accept", EVT_VALID, 0);
        EVT_READY = 1'b0;

        // ---- channel 3 glitch: 3 edges high then low ----
        rise_acc = '0;
        SYNC[3]  = 1'b1;
        repeat (3) begin tick(); rise_acc |= RISE; end
        SYNC[3]  = 1'b0;
        repeat (6) begin tick(); rise_acc |= RISE; end
        check("glitch_rise", rise_acc, 8'h00);
        check("glitch_db", DB, 8'h01);
        check("glitch_valid", EVT_VALID, 0);

        // ---- channels 1,5,6 together, consumer stalled 10 cycles ----
        SYNC = SYNC | 8'h62;
        repeat (4) tick();
        check("grp_db_edge4", DB, 8'h01);
        tick();
        check("grp_db", DB, 8'h63);
        check("grp_rise", RISE, 8'h62);
        repeat (10) tick();
        check("grp_valid", EVT_VALID, 1);
        check("grp_idx_a", EVT_IDX, 1);
        check("grp_level", EVT_LEVEL, 1);
        EVT_READY = 1'b1;
        tick();
        check("grp_valid_b", EVT_VALID, 1);
        check("grp_idx_b", EVT_IDX, 5);
        tick();
        check("grp_valid_c", EVT_VALID, 1);
        check("grp_idx_c", EVT_IDX, 6);
        tick();
        check("grp_drain", EVT_VALID, 0);
        EVT_READY = 1'b0;

        // ---- channels 2,7 together: pointer is 7, so 7 then 2 ----
        SYNC = SYNC | 8'h84;
        repeat (5) tick();
        check("pair_db", DB, 8'hE7);
        tick();
        check("pair_valid", EVT_VALID, 1);
        check("pair_idx_a", EVT_IDX, 7);
        EVT_READY = 1'b1;
        tick();
        check("pair_valid_b", EVT_VALID, 1);
        check("pair_idx_b", EVT_IDX, 2);
        tick();
        check("pair_drain", EVT_VALID, 0);
        EVT_READY = 1'b0;

`ifdef DEBOUNCE_FALL_EVT_EN
        // ---- channel 3 rises then falls while stalled: overrun, merged ----
        SYNC[3] = 1'b1;
        repeat (5) tick();
        check("ovf_db_rise", DB, 8'hEF);
        tick();
        check("ovf_valid", EVT_VALID, 1);
        check("ovf_idx", EVT_IDX, 3);
        check("ovf_level", EVT_LEVEL, 1);
        SYNC[3] = 1'b0;
        repeat (5) tick();
        check("ovf_db_fall", DB, 8'hE7);
        check("ovf_fall", FALL, 8'h08);
        check("ovf_set", OVERRUN, 1);
        tick();
        check("ovf_sticky", OVERRUN, 1);
        check("ovf_level_hold", EVT_LEVEL, 1);
        OVR_CLR = 1'b1;
        tick();
        check("ovf_clr", OVERRUN, 0);
        OVR_CLR   = 1'b0;
        EVT_READY = 1'b1;
        tick();
        check("ovf_single", EVT_VALID, 0);
        EVT_READY = 1'b0;
`else
        // ---- channel 4 rises then falls: one event only, no overrun ----
        SYNC[4] = 1'b1;
        repeat (4) tick();
        check("c4_db_edge4", DB, 8'hE7);
        tick();
        check("c4_db_rise", DB, 8'hF7);
        check("c4_rise", RISE, 8'h10);
        tick();
        check("c4_valid", EVT_VALID, 1);
        check("c4_idx", EVT_IDX, 4);
        check("c4_level", EVT_LEVEL, 1);
        SYNC[4] = 1'b0;
        repeat (5) tick();
        check("c4_db_fall", DB, 8'hE7);
        check("c4_fall", FALL, 8'h10);
        check("c4_no_ovr", OVERRUN, 0);
        check("c4_level_hold", EVT_LEVEL, 1);
        tick();
        check("c4_fall_off", FALL, 8'h00);
        EVT_READY = 1'b1;
        tick();
        check("c4_accept", EVT_VALID, 0);
        tick();
        check("c4_one_event", EVT_VALID, 0);
        EVT_READY = 1'b0;

        // ---- channel 3 rise, fall, rise while stalled: overrun ----
        SYNC[3] = 1'b1;
        repeat (5) tick();
        check("c3_rise1", RISE, 8'h08);
        tick();
        check("c3_valid", EVT_VALID, 1);
        check("c3_idx", EVT_IDX, 3);
        SYNC[3] = 1'b0;
        repeat (5) tick();
        check("c3_fall", FALL, 8'h08);
        check("c3_fall_no_ovr", OVERRUN, 0);
        SYNC[3] = 1'b1;
        repeat (5) tick();
        check("c3_rise2", RISE, 8'h08);
        check("c3_ovr", OVERRUN, 1);
        tick();
        check("c3_ovr_sticky", OVERRUN, 1);
        OVR_CLR = 1'b1;
        tick();
        check("c3_ovr_clr", OVERRUN, 0);
        OVR_CLR   = 1'b0;
        EVT_READY = 1'b1;
        tick();
        check("c3_merged", EVT_VALID, 0);
        EVT_READY = 1'b0;
`endif

        // ---- reset mid-handshake and mid-PEND ----
        SYNC[4] = 1'b1;
        repeat (5) tick();
        check("rs_db4", DB[4], 1);
        tick();
        check("rs_valid", EVT_VALID, 1);
        check("rs_idx", EVT_IDX, 4);
        SYNC[0] = 1'b0;
        tick();
        tick();
        #2;
        ACLR_L = 1'b0;
        #1;
        check("rs_db", DB, 8'h00);
        check("rs_valid_clr", EVT_VALID, 0);
        check("rs_idx_clr", EVT_IDX, 0);
        check("rs_level_clr", EVT_LEVEL, 0);
        check("rs_rise_clr", RISE, 8'h00);
        check("rs_fall_clr", FALL, 8'h00);
        check("rs_ovr_clr", OVERRUN, 0);
        SYNC = 8'h01;
        tick();
        ACLR_L = 1'b1;
        repeat (4) tick();
        check("post_db_edge4", DB, 8'h00);
        tick();
        check("post_db", DB, 8'h01);
        check("post_rise", RISE, 8'h01);
        tick();
        check("post_valid", EVT_VALID, 1);
        check("post_idx", EVT_IDX, 0);
        check("post_level", EVT_LEVEL, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
